ext_mem_burst: RTL and testbench

- Parametrised external-memory model with a request/ready command handshake, configurable wait-state latency and incrementing bursts of up to 2^BLEN_W beats.
- Sits behind the system bus as the off-chip memory stand-in for the datapath. Replaces the fixed 11-bit single-access memory.
- The memory array is internal: a word array of depth 2^ADDR_W.

---
 rtl/ext_mem_burst.sv | 202 ++++++++++++++++++++
 tb/tb_ext_mem_burst.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_mem_burst.sv
// ---------------------------------------------------------------------------
// ext_mem_burst : external-memory stand-in with request/ready command
// handshake, configurable wait-state latency and incrementing bursts.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   command valid (held by requester until accepted)
//   req_ready  out  command accept, high only in IDLE
//   req_we     in   1 = write burst, 0 = read burst
//   req_addr   in   burst start word address
//   req_len    in   burst beats minus one
//   wr_data    in   write beat data
//   wr_valid   in   write beat valid
//   wr_ready   out  write beat accept, high in XFER of a write burst
//   rd_data    out  registered read data
//   rd_valid   out  read beat valid (no backpressure)
//   rd_last    out  final read beat, qualified by rd_valid
//   busy       out  high whenever the FSM is not in IDLE
//   wrap_err   out  one-cycle pulse when a burst wraps past the top address
//   wr_be      in   per-byte write enables (only with EXT_MEM_BYTE_WE_EN)
//
// Build option: define EXT_MEM_BYTE_WE_EN to add byte-enabled writes
// (DATA_W must then be a multiple of 8).
// The memory array is deliberately not cleared by reset.
// ---------------------------------------------------------------------------
module ext_mem_burst #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 16,
    parameter int BLEN_W      = 3,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [BLEN_W-1:0] req_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              busy,
`ifdef EXT_MEM_BYTE_WE_EN
    input  logic [DATA_W/8-1:0] wr_be,
`endif
    output logic              wrap_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_XFER = 2'd2
    } state_e;

    localparam int WCNT_W = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);
    localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(WAIT_STATES);
    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    state_e            state_q,    state_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [BLEN_W-1:0] len_q,      len_d;
    logic [BLEN_W-1:0] beat_q,     beat_d;
    logic [WCNT_W-1:0] wait_q,     wait_d;
    logic              we_q,       we_d;
    logic [DATA_W-1:0] rd_data_q,  rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q,  rd_last_d;
    logic              wrap_err_q, wrap_err_d;
    logic              beat_fire_s;
    logic              mem_we_s;

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign wr_ready  = (state_q == ST_XFER) && we_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign wrap_err  = wrap_err_q;

    // Read beats fire every XFER cycle; write beats only when data is offered.
    assign beat_fire_s = (state_q == ST_XFER) && (!we_q || wr_valid);

    // Next-state and output decode for the burst FSM.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_d     = beat_q;
        wait_d     = wait_q;
        we_d       = we_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        wrap_err_d = 1'b0;
        mem_we_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    len_d  = req_len;
                    we_d   = req_we;
                    beat_d = '0;
                    wait_d = WAIT_INIT;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_XFER;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                wait_d = wait_q - WCNT_W'(1);
                // Leave on the edge where the counter lands on zero.
                if (wait_q <= WCNT_W'(1)) begin
                    state_d = ST_XFER;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_XFER: begin
                if (beat_fire_s) begin
                    addr_d = addr_q + ADDR_W'(1);
                    beat_d = beat_q + BLEN_W'(1);
                    // Only flag a wrap if another beat will use address 0.
                    if ((addr_q == ADDR_MAX) && (beat_q != len_q)) begin
                        wrap_err_d = 1'b1;
                    end else begin
                        wrap_err_d = 1'b0;
                    end
                    if (!we_q) begin
                        rd_data_d  = mem_q[addr_q];
                        rd_valid_d = 1'b1;
                        rd_last_d  = (beat_q == len_q);
                    end else begin
                        mem_we_s = 1'b1;
                    end
                    if (beat_q == len_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_XFER;
                    end
                end else begin
                    state_d = ST_XFER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            wait_q     <= '0;
            we_q       <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            wrap_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            wait_q     <= wait_d;
            we_q       <= we_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            wrap_err_q <= wrap_err_d;
        end
    end

    // Memory array write port; a beat coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (mem_we_s && !rst) begin
`ifdef EXT_MEM_BYTE_WE_EN
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (wr_be[b]) begin
                    mem_q[addr_q][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
`else
            mem_q[addr_q] <= wr_data;
`endif
        end
    end

endmodule

// File: tb/tb_ext_mem_burst.sv
module tb_ext_mem_burst;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [10:0] req_addr;
    logic [2:0]  req_len;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_last;
    logic        busy;
    logic        wrap_err;
    logic [1:0]  wr_be;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] wq[$];
    int          n_cmp = 0;
    int          n_err = 0;

    ext_mem_burst dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_last   (rd_last),
        .busy      (busy),
`ifdef EXT_MEM_BYTE_WE_EN
        .wr_be     (wr_be),
`endif
        .wrap_err  (wrap_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Read-data scoreboard: every valid beat must match the oldest expectation.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (sb_q.size() == 0) begin
                check_val("rd_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val("rd_data", {16'd0, rd_data}, {16'd0, e.data});
                check_val("rd_last", {31'd0, rd_last}, {31'd0, e.last});
            end
        end
    end

    task automatic push_exp(input logic [15:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        sb_q.push_back(e);
    endtask

    // Returns 1 ns after the acceptance edge with req_valid dropped.
    task automatic issue(input logic we, input logic [10:0] addr, input logic [2:0] len);
        int cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_len   = len;
        cnt = 0;
        while (!req_ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 100) check_val("req_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic write_burst(input logic [10:0] addr, input logic [2:0] len,
                               input int stall_at, input int stall_n);
        int cnt;
        issue(1'b1, addr, len);
        for (int i = 0; i <= int'(len); i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge clk);
                    wr_valid = 1'b0;
                    check_val("wr_ready_stall", {31'd0, wr_ready}, 32'd1);
                end
            end
            @(negedge clk);
            wr_valid = 1'b1;
            wr_data  = wq[i];
            if (i > 0) check_val("wr_ready_xfer", {31'd0, wr_ready}, 32'd1);
            cnt = 0;
            while (!wr_ready && cnt < 50) begin
                @(negedge clk);
                cnt++;
            end
            if (cnt >= 50) check_val("wr_timeout", 32'd1, 32'd0);
            @(posedge clk);
        end
        #1 wr_valid = 1'b0;
        @(negedge clk);
        check_val("wr_done_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_drain();
        int cnt;
        cnt = 0;
        while ((sb_q.size() != 0 || busy || rd_valid) && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 200) check_val("drain_timeout", 32'd1, 32'd0);
    endtask

    // Checks rd_valid stays low for WAIT_STATES+1 samples then rises.
    task automatic check_latency(input string tag);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val({tag, "_early"}, {31'd0, rd_valid}, 32'd0);
        end
        @(negedge clk);
        check_val({tag, "_first"}, {31'd0, rd_valid}, 32'd1);
    endtask

    initial begin
        int nvalid, nwrap, first_k, last_k;
        logic [15:0] wrap_data;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
        wr_data = '0; wr_valid = 1'b0; wr_be = 2'b11;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_val("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check_val("rst_wr_ready",  {31'd0, wr_ready},  32'd0);
        check_val("rst_busy",      {31'd0, busy},      32'd0);
        check_val("rst_rd_valid",  {31'd0, rd_valid},  32'd0);
        check_val("rst_rd_last",   {31'd0, rd_last},   32'd0);
        check_val("rst_wrap_err",  {31'd0, wrap_err},  32'd0);
        check_val("rst_rd_data",   {16'd0, rd_data},   32'd0);

        // Single write then single read with exact latency.
        wq = '{16'hBEEF};
        write_burst(11'h010, 3'd0, -1, 0);
        push_exp(16'hBEEF, 1'b1);
        issue(1'b0, 11'h010, 3'd0);
        check_latency("single_lat");
        @(negedge clk);
        check_val("single_valid_off", {31'd0, rd_valid}, 32'd0);
        check_val("single_busy_off",  {31'd0, busy},     32'd0);

        // Wrapping burst across the top of the array.
        wq = '{16'd1, 16'd2, 16'd3, 16'd4};
        write_burst(11'h7FE, 3'd3, -1, 0);
        wait_drain();
        push_exp(16'd1, 1'b0); push_exp(16'd2, 1'b0);
        push_exp(16'd3, 1'b0); push_exp(16'd4, 1'b1);
        issue(1'b0, 11'h7FE, 3'd3);
        nvalid = 0; nwrap = 0; first_k = -1; last_k = -1; wrap_data = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rd_valid) begin
                nvalid++;
                if (first_k < 0) first_k = k;
                last_k = k;
            end
            if (wrap_err) begin
                nwrap++;
                wrap_data = rd_data;
            end
        end
        check_val("wrap_beats",      nvalid,          32'd4);
        check_val("wrap_contiguous", last_k - first_k, 32'd3);
        check_val("wrap_pulses",     nwrap,           32'd1);
        check_val("wrap_align",      {16'd0, wrap_data}, 32'd2);
        wait_drain();

        // Stalled write burst, then readback.
        wq = '{16'hA0, 16'hA1, 16'hA2, 16'hA3};
        write_burst(11'h100, 3'd3, 1, 2);
        for (int i = 0; i < 4; i++) push_exp(wq[i], i == 3);
        issue(1'b0, 11'h100, 3'd3);
        wait_drain();

        // Busy rejection: second request held during an 8-beat read.
        wq.delete();
        for (int i = 0; i < 8; i++) wq.push_back(16'h3000 + 16'(i));
        write_burst(11'h200, 3'd7, -1, 0);
        for (int i = 0; i < 8; i++) push_exp(wq[i], i == 7);
        issue(1'b0, 11'h200, 3'd7);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 11'h010; req_len = 3'd0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_val("busy_req_ready_low", {31'd0, req_ready}, 32'd0);
        end
        @(negedge clk);
        check_val("busy_req_ready_high", {31'd0, req_ready}, 32'd1);
        push_exp(16'hBEEF, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        check_latency("b2b_lat");
        wait_drain();

        // Reset during beat 3 of an 8-beat read.
        wq = '{16'h5A5A};
        write_burst(11'h020, 3'd0, -1, 0);
        push_exp(16'h3000, 1'b0); push_exp(16'h3001, 1'b0);
        issue(1'b0, 11'h200, 3'd7);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("mrst_rd_valid",  {31'd0, rd_valid},  32'd0);
        check_val("mrst_busy",      {31'd0, busy},      32'd0);
        check_val("mrst_req_ready", {31'd0, req_ready}, 32'd1);
        check_val("mrst_sb_empty",  sb_q.size(),        32'd0);
        rst = 1'b0;
        push_exp(16'h5A5A, 1'b1);
        issue(1'b0, 11'h020, 3'd0);
        wait_drain();

`ifdef EXT_MEM_BYTE_WE_EN
        // Byte-enabled partial write.
        wq = '{16'h1234};
        wr_be = 2'b11;
        write_burst(11'h030, 3'd0, -1, 0);
        wq = '{16'hFFFF};
        wr_be = 2'b01;
        write_burst(11'h030, 3'd0, -1, 0);
        wr_be = 2'b11;
        push_exp(16'h12FF, 1'b1);
        issue(1'b0, 11'h030, 3'd0);
        wait_drain();
`endif

        repeat (3) @(negedge clk);
        check_val("sb_final_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
